// File: rtl/alu_pipe_param.sv
// Parametrised handshaked ALU: single-cycle logic/compare ops, iterative shift-add MUL.
// Optional saturation of ADD/SUB/MUL errors when ALU_SAT_EN is defined.
module alu_pipe_param #(
  parameter int          WIDTH    = 8,
  parameter logic [31:0] ERR_CODE = 32'h0000_00EE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ia,
  input  logic [WIDTH-1:0] ib,
  input  logic [3:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] oa,
  output logic             err
);

  localparam int               CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] ERR_V   = WIDTH'(ERR_CODE);
  localparam logic [3:0]       F_MUL   = 4'hC;

`ifdef ALU_SAT_EN
  localparam logic [WIDTH-1:0] OVF_V = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] UNF_V = {WIDTH{1'b0}};
`else
  localparam logic [WIDTH-1:0] OVF_V = ERR_V;
  localparam logic [WIDTH-1:0] UNF_V = ERR_V;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   oa_q, oa_d;
  logic               err_q, err_d;

  logic               accept_s;
  logic               load_mul_s;
  logic               load_alu_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_err_s;
  logic [2*WIDTH-1:0] acc_step_s;
  logic               mul_ovf_s;
  logic               mul_last_s;

  assign in_ready   = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept_s   = in_valid & in_ready;
  assign load_mul_s = accept_s & (func == F_MUL);
  assign load_alu_s = accept_s & (func != F_MUL);

  assign sum_s  = {1'b0, ia} + {1'b0, ib};
  assign diff_s = {1'b0, ia} - {1'b0, ib};

  // MUL partial product; the last step's sum is the final product.
  assign acc_step_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
  assign mul_ovf_s  = |acc_step_s[2*WIDTH-1:WIDTH];
  assign mul_last_s = (state_q == BUSY) && (cnt_q == LAST);

  assign out_valid = (state_q == DONE);
  assign oa        = oa_q;
  assign err       = err_q;

  // Single-cycle operation result from the operands presented this cycle
  always_comb begin
    alu_res_s = '0;
    alu_err_s = 1'b0;
    case (func)
      4'h0: alu_res_s = ia & ib;
      4'h1: alu_res_s = ia | ib;
      4'h2: begin
        if (sum_s[WIDTH]) begin
          alu_res_s = OVF_V;
          alu_err_s = 1'b1;
        end else begin
          alu_res_s = sum_s[WIDTH-1:0];
        end
      end
      4'h3: begin
        if (diff_s[WIDTH]) begin
          alu_res_s = UNF_V;
          alu_err_s = 1'b1;
        end else begin
          alu_res_s = diff_s[WIDTH-1:0];
        end
      end
      4'h4: begin
        if (ib >= WIDTH_V) begin
          alu_res_s = '0;
        end else begin
          alu_res_s = ia << ib;
        end
      end
      4'h5: begin
        if (ib >= WIDTH_V) begin
          alu_res_s = '0;
        end else begin
          alu_res_s = ia >> ib;
        end
      end
      4'h6: begin
        if (ib >= WIDTH_V) begin
          alu_res_s = {WIDTH{ia[WIDTH-1]}};
        end else begin
          alu_res_s = $signed(ia) >>> ib;
        end
      end
      4'h7: alu_res_s = ia ^ ib;
      4'h8: alu_res_s = {{(WIDTH-1){1'b0}}, (ia == ib)};
      4'h9: alu_res_s = {{(WIDTH-1){1'b0}}, (ia >= ib)};
      4'hA: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(ia) < $signed(ib))};
      4'hB: alu_res_s = {{(WIDTH-1){1'b0}}, (ia < ib)};
      4'hC: alu_res_s = '0;
      4'hD: alu_res_s = (ia < ib) ? ia : ib;
      4'hE: alu_res_s = (ia > ib) ? ia : ib;
      default: begin
        alu_res_s = ERR_V;
        alu_err_s = 1'b1;
      end
    endcase
  end

  // Control state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_mul_s) begin
          state_d = BUSY;
        end else if (load_alu_s) begin
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (load_mul_s) begin
          state_d = BUSY;
        end else if (load_alu_s) begin
          state_d = DONE;
        end else if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Multiplier datapath and held result
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    oa_d     = oa_q;
    err_d    = err_q;
    if (load_mul_s) begin
      mcand_d  = {{WIDTH{1'b0}}, ia};
      mplier_d = ib;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (state_q == BUSY) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_step_s;
      cnt_d    = cnt_q + CW'(1);
    end else begin
      cnt_d    = cnt_q;
    end
    if (load_alu_s) begin
      oa_d  = alu_res_s;
      err_d = alu_err_s;
    end else if (mul_last_s) begin
      if (mul_ovf_s) begin
        oa_d  = OVF_V;
        err_d = 1'b1;
      end else begin
        oa_d  = acc_step_s[WIDTH-1:0];
        err_d = 1'b0;
      end
    end else begin
      oa_d  = oa_q;
      err_d = err_q;
    end
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      oa_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      oa_q     <= oa_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe_param.sv
// Directed self-checking bench for alu_pipe_param at WIDTH=8.
// Expected error results follow ALU_SAT_EN when the bench is built with it.
module tb_alu_pipe_param;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] ia;
  logic [7:0] ib;
  logic [3:0] func;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] oa;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

`ifdef ALU_SAT_EN
  localparam logic [7:0] OVF = 8'hFF;
  localparam logic [7:0] UNF = 8'h00;
`else
  localparam logic [7:0] OVF = 8'hEE;
  localparam logic [7:0] UNF = 8'hEE;
`endif

  logic [7:0] bp_a [10] = '{8'h00, 8'h0F, 8'hF0, 8'hFF, 8'h5A, 8'hA5, 8'h12, 8'h34, 8'h81, 8'h7E};
  logic [7:0] bp_x [10] = '{8'h5A, 8'h55, 8'hAA, 8'hA5, 8'h00, 8'hFF, 8'h48, 8'h6E, 8'hDB, 8'h24};
  logic [7:0] st_a [4]  = '{8'h10, 8'h20, 8'h30, 8'h40};
  logic [7:0] st_x [4]  = '{8'h11, 8'h21, 8'h31, 8'h41};

  alu_pipe_param #(.WIDTH(8), .ERR_CODE(32'h0000_00EE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ia        (ia),
    .ib        (ib),
    .func      (func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .oa        (oa),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Latency counts cycles from the accepting cycle to the first cycle with out_valid.
  task automatic run_and_check(input string tag, input logic [3:0] f, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] exp_r, input logic exp_e,
                               input int exp_lat);
    int lat;
    int waitc;
    @(negedge clk);
    in_valid = 1'b1;
    func     = f;
    ia       = a;
    ib       = b;
    waitc    = 0;
    #1;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, "_res"}, 32'(oa), 32'(exp_r));
    check_eq({tag, "_err"}, 32'(err), 32'(exp_e));
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int  sent;
    int  recv;
    bit  stall;
    bit  seen_valid;
    logic [7:0] held_oa;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ia        = 8'h00;
    ib        = 8'h00;
    func      = 4'h0;
    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_oa", 32'(oa), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_and_check("add_ovf",  4'h2, 8'hF0, 8'h20, OVF,   1'b1, 1);
    run_and_check("add_ok",   4'h2, 8'h10, 8'h20, 8'h30, 1'b0, 1);
    run_and_check("add_ff01", 4'h2, 8'hFF, 8'h01, OVF,   1'b1, 1);
    run_and_check("sub_unf",  4'h3, 8'h03, 8'h05, UNF,   1'b1, 1);
    run_and_check("sub_ok",   4'h3, 8'h05, 8'h03, 8'h02, 1'b0, 1);
    run_and_check("reserved", 4'hF, 8'h12, 8'h34, 8'hEE, 1'b1, 1);
    run_and_check("sra3",     4'h6, 8'h80, 8'h03, 8'hF0, 1'b0, 1);
    run_and_check("sra9",     4'h6, 8'h80, 8'h09, 8'hFF, 1'b0, 1);
    run_and_check("shl8",     4'h4, 8'h01, 8'h08, 8'h00, 1'b0, 1);
    run_and_check("shl2",     4'h4, 8'h03, 8'h02, 8'h0C, 1'b0, 1);
    run_and_check("shr7",     4'h5, 8'h80, 8'h07, 8'h01, 1'b0, 1);
    run_and_check("lts_ff01", 4'hA, 8'hFF, 8'h01, 8'h01, 1'b0, 1);
    run_and_check("lts_01ff", 4'hA, 8'h01, 8'hFF, 8'h00, 1'b0, 1);
    run_and_check("ltu_ff01", 4'hB, 8'hFF, 8'h01, 8'h00, 1'b0, 1);
    run_and_check("and",      4'h0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1);
    run_and_check("or",       4'h1, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1);
    run_and_check("xor",      4'h7, 8'h55, 8'hAA, 8'hFF, 1'b0, 1);
    run_and_check("eq",       4'h8, 8'h5A, 8'h5A, 8'h01, 1'b0, 1);
    run_and_check("geu",      4'h9, 8'h05, 8'h05, 8'h01, 1'b0, 1);
    run_and_check("minu",     4'hD, 8'h80, 8'h7F, 8'h7F, 1'b0, 1);
    run_and_check("maxu",     4'hE, 8'h80, 8'h7F, 8'h80, 1'b0, 1);
    run_and_check("mul_12x11", 4'hC, 8'h0C, 8'h0B, 8'h84, 1'b0, 9);
    run_and_check("mul_ovf",  4'hC, 8'h20, 8'h10, OVF,   1'b1, 9);
    run_and_check("mul_zero", 4'hC, 8'h00, 8'hFF, 8'h00, 1'b0, 9);
    run_and_check("mul_ffx1", 4'hC, 8'hFF, 8'h01, 8'hFF, 1'b0, 9);

    // back-to-back ADDs with out_ready held high: one result per cycle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_eq("tp_valid", 32'(out_valid), 32'd1);
        check_eq("tp_oa", 32'(oa), 32'(st_x[i-1]));
      end
      in_valid = (i < 4);
      func     = 4'h2;
      ia       = (i < 4) ? st_a[i] : 8'h00;
      ib       = 8'h01;
    end
    in_valid = 1'b0;

    // ten XORs with out_ready toggling
    sent  = 0;
    recv  = 0;
    stall = 1'b0;
    held_oa = 8'h00;
    for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
      @(negedge clk);
      if (stall) begin
        check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
        check_eq("bp_hold_oa", 32'(oa), 32'(held_oa));
      end
      out_ready = (cyc % 2 == 0);
      in_valid  = (sent < 10);
      func      = 4'h7;
      ia        = (sent < 10) ? bp_a[sent] : 8'h00;
      ib        = 8'h5A;
      #1;
      if (out_ready) check_eq("bp_in_ready", 32'(in_ready), 32'd1);
      stall   = out_valid & ~out_ready;
      held_oa = oa;
      if (out_valid && out_ready) begin
        check_eq("bp_data", 32'(oa), 32'(bp_x[recv]));
        recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("bp_count", 32'(recv), 32'd10);

    // reset in the middle of a multiply
    @(negedge clk);
    in_valid = 1'b1;
    func     = 4'hC;
    ia       = 8'h0C;
    ib       = 8'h0B;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("busy_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rstb_out_valid", 32'(out_valid), 32'd0);
    check_eq("rstb_oa", 32'(oa), 32'd0);
    check_eq("rstb_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rstb_in_ready", 32'(in_ready), 32'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check_eq("rstb_no_stale", 32'(seen_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
